seg7_display: RTL and testbench

Two-digit multiplexed seven-segment driver for the 5-bit counter value. Converts the binary input (0..31) to tens/units decimal digits and time-multiplexes them onto a common-anode, two-digit display. Latches the input once per frame so the display never tears. Blinks the display while the counter is paused. It sits between the counter's output bus and the board's segment and anode pins.

---
 rtl/seg7_pkg.sv | 27 ++
 rtl/seg7_encode.sv | 15 +
 rtl/seg7_display.sv | 135 +++++++++++++
 tb/tb_seg7_display.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the two-digit multiplexed seven-segment driver.
package seg7_pkg;

  typedef enum logic {
    S_UNITS = 1'b0,
    S_TENS  = 1'b1
  } seg7_state_t;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;

  // Active-low {g,f,e,d,c,b,a}; entry [n] is the code for digit n.
  localparam logic [9:0][6:0] SEG_CODES = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

endpackage

// File: rtl/seg7_encode.sv
// Decimal digit to active-low segment pattern; blank or any non-decimal digit gives all segments off.
module seg7_encode
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output seg_t       seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank && (digit <= 4'd9)) seg = SEG_CODES[digit];
  end

endmodule

// File: rtl/seg7_display.sv
// Two-digit multiplexed seven-segment driver with per-frame input latch and pause blink.
// state   | meaning
// S_UNITS | units digit slot, o_an = 10
// S_TENS  | tens digit slot, o_an = 01 (or dark when leading zero is blanked)
module seg7_display
  import seg7_pkg::*;
#(
  parameter int RefreshDiv       = 50000,
  parameter int BlinkFrames      = 64,
  parameter bit LeadingZeroBlank = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [4:0] i_data,
  input  logic       i_pause,
  output logic [6:0] o_seg,
  output logic [1:0] o_an,
  output logic       o_frame
);

  localparam int PW = $clog2(RefreshDiv);
  localparam logic [PW-1:0] PRE_LAST = PW'(RefreshDiv - 1);
  localparam int BW = (BlinkFrames > 1) ? $clog2(BlinkFrames) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BlinkFrames - 1);

  logic [PW-1:0] pre_cnt;
  logic          tick;
  logic          latch;
  seg7_state_t   state, state_nxt;
  logic [4:0]    shadow_data;
  logic          shadow_pause;
  logic [BW-1:0] blink_cnt;
  logic          phase;
  logic [1:0]    tens;
  logic [3:0]    units;
  logic          dark;
  logic          blank_lz;
  logic [3:0]    digit;
  logic          enc_blank;
  logic [1:0]    an_nxt;
  seg_t          seg_nxt;

  assign tick  = (pre_cnt == PRE_LAST);
  assign latch = tick && (state == S_TENS);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)   pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= S_UNITS;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (tick) state_nxt = (state == S_UNITS) ? S_TENS : S_UNITS;
  end

  // Blink counter only runs across consecutive paused frames; an unpaused latch restarts it visible.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      shadow_data  <= '0;
      shadow_pause <= 1'b0;
      blink_cnt    <= '0;
      phase        <= 1'b0;
    end else if (latch) begin
      shadow_data  <= i_data;
      shadow_pause <= i_pause;
      if (!i_pause) begin
        blink_cnt <= '0;
        phase     <= 1'b0;
      end else if (shadow_pause) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          phase     <= ~phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    if (shadow_data >= 5'd30) begin
      tens  = 2'd3;
      units = 4'(shadow_data - 5'd30);
    end else if (shadow_data >= 5'd20) begin
      tens  = 2'd2;
      units = 4'(shadow_data - 5'd20);
    end else if (shadow_data >= 5'd10) begin
      tens  = 2'd1;
      units = 4'(shadow_data - 5'd10);
    end else begin
      tens  = 2'd0;
      units = shadow_data[3:0];
    end
  end

  assign dark     = shadow_pause && phase;
  assign blank_lz = LeadingZeroBlank && (tens == 2'd0);

  always_comb begin
    digit     = units;
    enc_blank = dark;
    an_nxt    = 2'b10;
    if (state == S_TENS) begin
      digit     = {2'b00, tens};
      enc_blank = dark || blank_lz;
      an_nxt    = 2'b01;
    end
    if (enc_blank) an_nxt = 2'b11;
  end

  seg7_encode u_encode (
    .digit (digit),
    .blank (enc_blank),
    .seg   (seg_nxt)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_an    <= 2'b11;
      o_seg   <= SEG_BLANK;
      o_frame <= 1'b0;
    end else begin
      o_an    <= an_nxt;
      o_seg   <= seg_nxt;
      o_frame <= latch;
    end
  end

endmodule

// File: tb/tb_seg7_display.sv
// Directed bench for seg7_display with RefreshDiv=4, BlinkFrames=2; second instance has leading-zero blanking off.
module tb_seg7_display;

  localparam logic [6:0] C0 = 7'b1000000;
  localparam logic [6:0] C1 = 7'b1111001;
  localparam logic [6:0] C2 = 7'b0100100;
  localparam logic [6:0] C3 = 7'b0110000;
  localparam logic [6:0] C5 = 7'b0010010;
  localparam logic [6:0] C7 = 7'b1111000;
  localparam logic [6:0] C9 = 7'b0010000;
  localparam logic [6:0] BL = 7'b1111111;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b0;
  logic [4:0] i_data = 5'd0;
  logic       i_pause = 1'b0;
  logic [6:0] seg_a, seg_b;
  logic [1:0] an_a, an_b;
  logic       frame_a, frame_b;
  int         n_assert = 0;
  int         n_fail = 0;

  always #5 i_clk = ~i_clk;

  seg7_display #(.RefreshDiv(4), .BlinkFrames(2), .LeadingZeroBlank(1'b1)) dut_a (
    .i_clk(i_clk), .i_reset(i_reset), .i_data(i_data), .i_pause(i_pause),
    .o_seg(seg_a), .o_an(an_a), .o_frame(frame_a)
  );

  seg7_display #(.RefreshDiv(4), .BlinkFrames(2), .LeadingZeroBlank(1'b0)) dut_b (
    .i_clk(i_clk), .i_reset(i_reset), .i_data(i_data), .i_pause(i_pause),
    .o_seg(seg_b), .o_an(an_b), .o_frame(frame_b)
  );

  task automatic chk7(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One 8-cycle frame starting right after a latch; optional mid-frame input change at cycle chg_at.
  task automatic frame(input logic [1:0] u_an, input logic [6:0] u_seg,
                       input logic [1:0] t_an, input logic [6:0] t_seg,
                       input logic [1:0] t_an2, input logic [6:0] t_seg2,
                       input int chg_at = 0, input logic [4:0] chg_d = 5'd0,
                       input logic chg_p = 1'b0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge i_clk);
      if (i == chg_at) begin
        i_data  = chg_d;
        i_pause = chg_p;
      end
      if (i <= 4) begin
        chk2("an_units", an_a, u_an);
        chk7("seg_units", seg_a, u_seg);
        chk2("an_units_nolzb", an_b, u_an);
        chk7("seg_units_nolzb", seg_b, u_seg);
      end else begin
        chk2("an_tens", an_a, t_an);
        chk7("seg_tens", seg_a, t_seg);
        chk2("an_tens_nolzb", an_b, t_an2);
        chk7("seg_tens_nolzb", seg_b, t_seg2);
      end
      chk1("frame_pulse", frame_a, i == 8);
      chk1("frame_pulse_nolzb", frame_b, i == 8);
    end
  endtask

  initial begin
    int frames;
    int an_zero;

    #2 i_reset = 1'b1;
    #1;
    chk2("reset_an", an_a, 2'b11);
    chk7("reset_seg", seg_a, BL);
    chk1("reset_frame", frame_a, 1'b0);
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
    chk2("first_cycle_an", an_a, 2'b11);

    i_data = 5'd27;
    frame(2'b10, C0, 2'b11, BL, 2'b01, C0);
    i_data = 5'd0;
    frame(2'b10, C7, 2'b01, C2, 2'b01, C2);
    i_data = 5'd9;
    frame(2'b10, C0, 2'b11, BL, 2'b01, C0);
    i_data = 5'd10;
    frame(2'b10, C9, 2'b11, BL, 2'b01, C0);
    i_data = 5'd30;
    frame(2'b10, C0, 2'b01, C1, 2'b01, C1);
    i_data = 5'd31;
    frame(2'b10, C0, 2'b01, C3, 2'b01, C3);
    i_data = 5'd5;
    frame(2'b10, C1, 2'b01, C3, 2'b01, C3);
    i_data = 5'd12;
    frame(2'b10, C5, 2'b11, BL, 2'b01, C0);
    // 12 latched; switch to 31 mid units slot, current frame must stay 1/2
    frame(2'b10, C2, 2'b01, C1, 2'b01, C1, 2, 5'd31, 1'b0);
    i_data = 5'd27;
    frame(2'b10, C1, 2'b01, C3, 2'b01, C3);

    // 27 latched; reset two cycles into its tens slot
    repeat (6) @(negedge i_clk);
    chk2("pre_reset_an", an_a, 2'b01);
    chk7("pre_reset_seg", seg_a, C2);
    #2 i_reset = 1'b1;
    #1;
    chk2("midslot_reset_an", an_a, 2'b11);
    chk7("midslot_reset_seg", seg_a, BL);
    chk1("midslot_reset_frame", frame_a, 1'b0);
    chk2("midslot_reset_an_nolzb", an_b, 2'b11);
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
    chk2("post_reset_first_an", an_a, 2'b11);
    i_data  = 5'd27;
    i_pause = 1'b0;
    frame(2'b10, C0, 2'b11, BL, 2'b01, C0);

    // Blink: two visible frames then two dark, drop pause in a dark frame
    i_pause = 1'b1;
    frame(2'b10, C7, 2'b01, C2, 2'b01, C2);
    frame(2'b10, C7, 2'b01, C2, 2'b01, C2);
    frame(2'b10, C7, 2'b01, C2, 2'b01, C2);
    frame(2'b11, BL, 2'b11, BL, 2'b11, BL);
    frame(2'b11, BL, 2'b11, BL, 2'b11, BL, 2, 5'd27, 1'b0);
    i_pause = 1'b1;
    frame(2'b10, C7, 2'b01, C2, 2'b01, C2);
    frame(2'b10, C7, 2'b01, C2, 2'b01, C2);
    frame(2'b10, C7, 2'b01, C2, 2'b01, C2);
    i_pause = 1'b0;
    frame(2'b11, BL, 2'b11, BL, 2'b11, BL);
    frame(2'b10, C7, 2'b01, C2, 2'b01, C2);

    frames  = 0;
    an_zero = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge i_clk);
      if (frame_a) frames++;
      if (an_a == 2'b00 || an_b == 2'b00) an_zero++;
    end
    chk_int("frame_count_1000", frames, 125);
    chk_int("an_never_00", an_zero, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
